ahb_lite_mem_slave: RTL and testbench
=====================================

// Module: ahb_lite_mem_slave
// PURPOSE
//  AHB-Lite responder: word-organised, byte-writable SRAM at the slave end of the master interface bundle.
//  Pairs with the UVM master agent as the DUT-side target for directed and random bus traffic.
//  Decodes address phase, runs a pipelined data phase with programmable wait states,
//  and drives hready/hresp/hrdata back to the master.
// PARAMETERS
//  MEM_DEPTH    256  number of 32-bit words; power of two, >= 4
//  WAIT_STATES  1    hready-low cycles inserted per NONSEQ/SEQ data phase; 0..15
// PORTS
//  hclk       in   1   bus clock; all logic on rising edge
//  hresetn    in   1   synchronous, active-low reset
//  hsel       in   1   slave select
//  haddr      in   32  byte address (address phase)
//  htrans     in   2   IDLE=00 BUSY=01 NONSEQ=10 SEQ=11
//  hwrite     in   1   1=write, 0=read
//  hsize      in   3   000=byte 001=half 010=word; others illegal
//  hburst     in   3   accepted, not decoded (every beat is self-addressed)
//  hwdata     in   32  write data (data phase)
//  hready     out  1   data-phase complete; the bus has a single slave, so no separate hreadyin
//  hresp      out  2   00=OKAY 01=ERROR
//  hrdata     out  32  read data, valid when hready=1 in a read data phase
// BEHAVIOUR
//  Reset (hresetn=0 at edge): state IDLE, hready=1, hresp=OKAY, hrdata=0; memory contents not reset.
//  Accept: hsel & htrans[1] & hready at edge -> latch addr/hwrite/hsize into data-phase regs.
//  IDLE/BUSY, or hsel=0, with hready=1: no access; next cycle OKAY, hready=1 (zero wait).
//  FSM: IDLE -> WAIT (WAIT_STATES>0) or DATA (WAIT_STATES=0) on accept.
//   WAIT: hready=0, counter counts down from WAIT_STATES; at 1 -> DATA.
//   DATA: hready=1, hresp=OKAY; a write commits at this edge; a read drives hrdata=mem[addr_q] combinationally.
//   DATA -> WAIT/DATA on a new accept (back-to-back pipelining), else IDLE.
//  New address phases are ignored while hready=0; master holds them, and they are sampled at the hready=1 edge.
//  Byte lanes are little-endian. byte: lane addr[1:0]. half: lanes {addr[1],0}+{0,1}. word: all four lanes.
//  Read-after-write to the same word, back-to-back: the read data phase follows the write commit and returns new data.
//  hrdata = 0 outside a read DATA cycle.
//  Word index = addr_q[log2(MEM_DEPTH)+1:2].
//  Reset asserted mid-transfer: pending write is dropped and the FSM returns to IDLE.
// CONFIGURATION
//  AHB_SLV_ERR_EN defined: an accepted transfer gets a two-cycle ERROR if any of these hold:
//   haddr >= 4*MEM_DEPTH; hsize > 010; address misaligned to hsize.
//   ERR1: hready=0, hresp=01. ERR2: hready=1, hresp=01. No memory write.
//   A new address phase presented in ERR2 is accepted normally.
//  AHB_SLV_ERR_EN undefined: no ERR states; hresp is tied to 00.
//   Upper address bits wrap modulo MEM_DEPTH; misaligned low bits are masked; hsize>010 is treated as word.
// STRUCTURE
//  ahb_lite_pkg: htrans_e, hsize_e, hresp_e codes and slv_state_e {IDLE,WAIT,DATA,ERR1,ERR2}.
//  Sub-module ahb_slv_mem_array: MEM_DEPTH x 32 RAM, 4-bit byte write enable, async read port.
//  Top level holds the FSM, wait counter, data-phase regs, lane decode and error check.
// TESTING
//  1 Reset: hresetn=0 for 2 cycles -> hready=1, hresp=00, hrdata=0.
//  2 WAIT_STATES=1: word write 0x10<=0xDEADBEEF, then read 0x10 -> hready low 1 cycle each; read returns 0xDEADBEEF.
//  3 Byte write 0x0000_00AA to addr 0x13 over word 0x11223344 -> read 0x10 returns 0xAA223344.
//  4 WAIT_STATES=0: back-to-back NONSEQ write 0x20<=5, then read 0x20 -> hready always 1; read returns 5.
//  5 AHB_SLV_ERR_EN: read 0x400 (depth 256) -> ERR1 (hready=0, hresp=01), then ERR2 (hready=1, hresp=01).
//  6 Reset asserted during a WAIT of a write to 0x8 -> FSM IDLE, and a later read of 0x8 returns the old value.

Source files
------------

// File: rtl/ahb_lite_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_pkg
// Purpose  : AHB-Lite bus codes, slave FSM states and byte-lane decode helper.
// Revision : 1.0  initial release
// ============================================================================
package ahb_lite_pkg;

  localparam int unsigned c_data_w = 32;

  typedef enum logic [1:0] {
    HTRANS_IDLE   = 2'b00,
    HTRANS_BUSY   = 2'b01,
    HTRANS_NONSEQ = 2'b10,
    HTRANS_SEQ    = 2'b11
  } htrans_e;

  typedef enum logic [2:0] {
    HSIZE_BYTE = 3'b000,
    HSIZE_HALF = 3'b001,
    HSIZE_WORD = 3'b010
  } hsize_e;

  typedef enum logic [1:0] {
    HRESP_OKAY  = 2'b00,
    HRESP_ERROR = 2'b01
  } hresp_e;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    WAIT = 3'd1,
    DATA = 3'd2,
    ERR1 = 3'd3,
    ERR2 = 3'd4
  } slv_state_e;

  // Little-endian lane enables; illegal sizes fall through to a full word.
  function automatic logic [3:0] byte_lanes(input logic [2:0] size, input logic [1:0] a);
    case (size)
      HSIZE_BYTE: return 4'b0001 << a;
      HSIZE_HALF: return a[1] ? 4'b1100 : 4'b0011;
      default:    return 4'b1111;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/ahb_slv_mem_array.sv
`default_nettype none
// ============================================================================
// Module   : ahb_slv_mem_array
// Purpose  : DEPTH x 32 RAM with per-byte write enable and asynchronous read.
// Revision : 1.0  initial release
// ============================================================================
module ahb_slv_mem_array
  import ahb_lite_pkg::*;
#(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = $clog2(DEPTH)
) (
  input  logic                i_clk,
  input  logic [3:0]          i_we,
  input  logic [AW-1:0]       i_addr,
  input  logic [c_data_w-1:0] i_wdata,
  output logic [c_data_w-1:0] o_rdata
);

  logic [c_data_w-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    for (int b = 0; b < 4; b++) begin
      if (i_we[b]) r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
    end
  end

  assign o_rdata = r_mem[i_addr];

endmodule
`default_nettype wire

// File: rtl/ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : ahb_lite_mem_slave
// Purpose  : AHB-Lite SRAM responder with programmable wait states.
//            Optional error responses enabled by defining AHB_SLV_ERR_EN.
// Revision : 1.0  initial release
// ============================================================================
module ahb_lite_mem_slave
  import ahb_lite_pkg::*;
#(
  parameter int unsigned MEM_DEPTH   = 256,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic                hclk,
  input  logic                hresetn,
  input  logic                hsel,
  input  logic [31:0]         haddr,
  input  logic [1:0]          htrans,
  input  logic                hwrite,
  input  logic [2:0]          hsize,
  input  logic [2:0]          hburst,
  input  logic [c_data_w-1:0] hwdata,
  output logic                hready,
  output logic [1:0]          hresp,
  output logic [c_data_w-1:0] hrdata
);

  localparam int unsigned c_aw = $clog2(MEM_DEPTH);
  localparam logic [3:0]  c_ws = 4'(WAIT_STATES);

  slv_state_e          r_state, w_state_nxt;
  logic [3:0]          r_wcnt, w_wcnt_nxt;
  logic [c_aw+1:0]     r_addr;
  logic                r_write;
  logic [2:0]          r_size;
  logic                w_accept;
  logic                w_err;
  logic [3:0]          w_we;
  logic [c_data_w-1:0] w_rdata;
  logic                w_unused;

  assign hready   = (r_state != WAIT) && (r_state != ERR1);
  assign w_accept = hsel & htrans[1] & hready;
  assign w_unused = ^{hburst, haddr[31:c_aw+2]};

`ifdef AHB_SLV_ERR_EN
  assign w_err = (haddr[31:c_aw+2] != '0) ||
                 (hsize > HSIZE_WORD) ||
                 ((hsize == HSIZE_HALF) && haddr[0]) ||
                 ((hsize == HSIZE_WORD) && (haddr[1:0] != 2'b00));
  assign hresp = ((r_state == ERR1) || (r_state == ERR2)) ? HRESP_ERROR : HRESP_OKAY;
`else
  assign w_err = 1'b0;
  assign hresp = HRESP_OKAY;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_wcnt_nxt  = r_wcnt;
    case (r_state)
      WAIT: begin
        if (r_wcnt <= 4'd1) w_state_nxt = DATA;
        else                w_wcnt_nxt  = r_wcnt - 4'd1;
      end
      ERR1: w_state_nxt = ERR2;
      // IDLE, DATA and ERR2 all drive hready high and can take a new transfer
      default: begin
        if (w_accept) begin
          if (w_err) begin
            w_state_nxt = ERR1;
          end else if (c_ws == 4'd0) begin
            w_state_nxt = DATA;
          end else begin
            w_state_nxt = WAIT;
            w_wcnt_nxt  = c_ws;
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge hclk) begin
    if (!hresetn) begin
      r_state <= IDLE;
      r_wcnt  <= '0;
      r_addr  <= '0;
      r_write <= 1'b0;
      r_size  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_wcnt  <= w_wcnt_nxt;
      if (w_accept) begin
        r_addr  <= haddr[c_aw+1:0];
        r_write <= hwrite;
        r_size  <= hsize;
      end
    end
  end

  // Write is gated by reset so a transfer cut short by reset never lands.
  assign w_we = (hresetn && (r_state == DATA) && r_write) ? byte_lanes(r_size, r_addr[1:0]) : 4'b0000;

  ahb_slv_mem_array #(
    .DEPTH (MEM_DEPTH),
    .AW    (c_aw)
  ) u_mem (
    .i_clk   (hclk),
    .i_we    (w_we),
    .i_addr  (r_addr[c_aw+1:2]),
    .i_wdata (hwdata),
    .o_rdata (w_rdata)
  );

  assign hrdata = ((r_state == DATA) && !r_write) ? w_rdata : '0;

endmodule
`default_nettype wire

// File: tb/tb_ahb_lite_mem_slave.sv
`default_nettype none
// ============================================================================
// Module   : tb_ahb_lite_mem_slave
// Purpose  : Directed and random checks of two slaves (0 and 1 wait states).
// Revision : 1.0  initial release
// ============================================================================
module tb_ahb_lite_mem_slave;

  localparam int unsigned c_depth = 256;
  localparam int unsigned c_ws0   = 0;
  localparam int unsigned c_ws1   = 1;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        hsel   [2];
  logic [31:0] haddr  [2];
  logic [1:0]  htrans [2];
  logic        hwrite [2];
  logic [2:0]  hsize  [2];
  logic [2:0]  hburst [2];
  logic [31:0] hwdata [2];
  logic        hready [2];
  logic [1:0]  hresp  [2];
  logic [31:0] hrdata [2];

  int errors = 0;
  int checks = 0;
  logic [7:0] mdl [2][4*c_depth];

  always #5 hclk = ~hclk;

  ahb_lite_mem_slave #(.MEM_DEPTH(c_depth), .WAIT_STATES(c_ws0)) dut0 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[0]), .haddr(haddr[0]), .htrans(htrans[0]),
    .hwrite(hwrite[0]), .hsize(hsize[0]), .hburst(hburst[0]), .hwdata(hwdata[0]),
    .hready(hready[0]), .hresp(hresp[0]), .hrdata(hrdata[0]));

  ahb_lite_mem_slave #(.MEM_DEPTH(c_depth), .WAIT_STATES(c_ws1)) dut1 (
    .hclk(hclk), .hresetn(hresetn), .hsel(hsel[1]), .haddr(haddr[1]), .htrans(htrans[1]),
    .hwrite(hwrite[1]), .hsize(hsize[1]), .hburst(hburst[1]), .hwdata(hwdata[1]),
    .hready(hready[1]), .hresp(hresp[1]), .hrdata(hrdata[1]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: a flat byte array addressed modulo the memory size.
  function automatic int nbytes(input logic [2:0] sz);
    return (sz > 3'd2) ? 4 : (1 << sz);
  endfunction

  function automatic int base_of(input logic [31:0] a, input logic [2:0] sz);
    int x;
    x = int'(a % (4 * c_depth));
    return x - (x % nbytes(sz));
  endfunction

  task automatic mdl_write(input int d, input logic [31:0] a, input logic [2:0] sz, input logic [31:0] wd);
    int b;
    b = base_of(a, sz);
    for (int k = 0; k < nbytes(sz); k++) mdl[d][b+k] = wd[8*((b+k)%4) +: 8];
  endtask

  function automatic logic [31:0] mdl_read(input int d, input logic [31:0] a);
    int b;
    b = base_of(a, 3'd2);
    return {mdl[d][b+3], mdl[d][b+2], mdl[d][b+1], mdl[d][b]};
  endfunction

  // Masters replicate sub-word data across all lanes.
  function automatic logic [31:0] fill(input logic [2:0] sz, input logic [31:0] v);
    case (sz)
      3'd0:    return {4{v[7:0]}};
      3'd1:    return {2{v[15:0]}};
      default: return v;
    endcase
  endfunction

  task automatic bus_idle(input int d);
    hsel[d] = 1'b0; htrans[d] = 2'b00; hwrite[d] = 1'b0;
  endtask

  task automatic addr_phase(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz);
    hsel[d] = 1'b1; htrans[d] = 2'b10; haddr[d] = a; hwrite[d] = wr; hsize[d] = sz;
    hburst[d] = 3'($urandom_range(0, 7));
  endtask

  task automatic wait_ready(input int d, output int waits);
    waits = 0;
    for (int i = 0; i < 40 && hready[d] !== 1'b1; i++) begin
      waits++;
      @(negedge hclk);
    end
    check("ready_timeout", 32'(hready[d]), 32'd1);
  endtask

  task automatic xfer(input int d, input bit wr, input logic [31:0] a, input logic [2:0] sz,
                      input logic [31:0] wd, output logic [31:0] rd, output logic [1:0] resp,
                      output int waits);
    @(negedge hclk); addr_phase(d, wr, a, sz);
    @(negedge hclk); bus_idle(d); hwdata[d] = wd;
    wait_ready(d, waits);
    rd = hrdata[d]; resp = hresp[d];
  endtask

  // Write immediately followed by a pipelined read presented in its data phase.
  task automatic pair(input int d, input logic [31:0] wa, input logic [2:0] wsz, input logic [31:0] wd,
                      input logic [31:0] ra, output int w1, output int w2,
                      output logic [31:0] rd, output logic [1:0] resp1);
    @(negedge hclk); addr_phase(d, 1'b1, wa, wsz);
    @(negedge hclk); hwdata[d] = wd; addr_phase(d, 1'b0, ra, 3'd2);
    wait_ready(d, w1); resp1 = hresp[d];
    @(negedge hclk); bus_idle(d);
    wait_ready(d, w2); rd = hrdata[d];
  endtask

  initial begin
    logic [31:0] rd, a, wd;
    logic [1:0]  resp;
    logic [2:0]  sz;
    int          waits, w1, w2, d;
    bit          wr;

    hresetn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus_idle(i); haddr[i] = '0; hsize[i] = '0; hburst[i] = '0; hwdata[i] = '0;
    end
    repeat (2) @(negedge hclk);
    for (int i = 0; i < 2; i++) begin
      check("reset_hready", 32'(hready[i]), 32'd1);
      check("reset_hresp",  32'(hresp[i]),  32'd0);
      check("reset_hrdata", hrdata[i],      32'd0);
    end
    hresetn = 1'b1;

    for (int i = 0; i < 2; i++) begin
      for (int w = 0; w < 16; w++) begin
        wd = $urandom;
        xfer(i, 1'b1, 32'(4*w), 3'd2, wd, rd, resp, waits);
        mdl_write(i, 32'(4*w), 3'd2, wd);
      end
    end

    xfer(1, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF, rd, resp, waits);
    mdl_write(1, 32'h10, 3'd2, 32'hDEADBEEF);
    check("ws1_write_waits", 32'(waits), 32'd1);
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits);
    check("ws1_read_waits", 32'(waits), 32'd1);
    check("ws1_read_data", rd, mdl_read(1, 32'h10));

    xfer(1, 1'b1, 32'h10, 3'd2, 32'h11223344, rd, resp, waits);
    mdl_write(1, 32'h10, 3'd2, 32'h11223344);
    xfer(1, 1'b1, 32'h13, 3'd0, fill(3'd0, 32'hAA), rd, resp, waits);
    mdl_write(1, 32'h13, 3'd0, fill(3'd0, 32'hAA));
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits);
    check("byte_lane3", rd, mdl_read(1, 32'h10));

    pair(0, 32'h20, 3'd2, 32'd5, 32'h20, w1, w2, rd, resp);
    mdl_write(0, 32'h20, 3'd2, 32'd5);
    check("ws0_b2b_write_waits", 32'(w1), 32'd0);
    check("ws0_b2b_read_waits",  32'(w2), 32'd0);
    check("ws0_b2b_read_data",   rd, mdl_read(0, 32'h20));

    wd = $urandom;
    pair(1, 32'h30, 3'd2, wd, 32'h30, w1, w2, rd, resp);
    mdl_write(1, 32'h30, 3'd2, wd);
    check("ws1_raw_waits", 32'(w1 + w2), 32'd2);
    check("ws1_raw_data",  rd, mdl_read(1, 32'h30));

`ifdef AHB_SLV_ERR_EN
    for (int i = 0; i < 2; i++) begin
      xfer(i, 1'b0, 32'h400, 3'd2, 32'h0, rd, resp, waits);
      check("err_oob_err1_cycles", 32'(waits), 32'd1);
      check("err_oob_hresp",       32'(resp),  32'd1);
    end
    xfer(1, 1'b1, 32'h12, 3'd2, 32'h0BADF00D, rd, resp, waits);
    check("err_misalign_hresp", 32'(resp), 32'd1);
    xfer(1, 1'b1, 32'h20, 3'd3, 32'h0BADF00D, rd, resp, waits);
    check("err_size_hresp", 32'(resp), 32'd1);
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits);
    check("err_no_write_10", rd, mdl_read(1, 32'h10));
    xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, resp, waits);
    check("err_no_write_20", rd, mdl_read(1, 32'h20));
    pair(1, 32'h402, 3'd2, 32'h0BADF00D, 32'h10, w1, w2, rd, resp);
    check("err2_accept_err_resp", 32'(resp), 32'd1);
    check("err2_accept_waits",    32'(w1 + w2), 32'd2);
    check("err2_accept_data",     rd, mdl_read(1, 32'h10));
`else
    wd = fill(3'd1, 32'h5A5A);
    xfer(1, 1'b1, 32'h13, 3'd1, wd, rd, resp, waits);
    mdl_write(1, 32'h13, 3'd1, wd);
    check("mask_half_hresp", 32'(resp), 32'd0);
    xfer(1, 1'b0, 32'h10, 3'd2, 32'h0, rd, resp, waits);
    check("mask_half_data", rd, mdl_read(1, 32'h10));
    wd = $urandom;
    xfer(1, 1'b1, 32'h21, 3'd3, wd, rd, resp, waits);
    mdl_write(1, 32'h21, 3'd3, wd);
    xfer(1, 1'b0, 32'h20, 3'd2, 32'h0, rd, resp, waits);
    check("bigsize_as_word", rd, mdl_read(1, 32'h20));
    xfer(1, 1'b0, 32'h410, 3'd2, 32'h0, rd, resp, waits);
    check("wrap_read_data",  rd, mdl_read(1, 32'h410));
    check("wrap_read_hresp", 32'(resp), 32'd0);
`endif

    for (int n = 0; n < 60; n++) begin
      d  = int'($urandom_range(0, 1));
      wr = 1'($urandom_range(0, 1));
      sz = 3'($urandom_range(0, 2));
      a  = 32'($urandom_range(0, 63)) & ~32'(nbytes(sz) - 1);
      wd = fill(sz, $urandom);
      xfer(d, wr, a, sz, wd, rd, resp, waits);
      check("rnd_waits", 32'(waits), (d == 0) ? 32'(c_ws0) : 32'(c_ws1));
      check("rnd_hresp", 32'(resp), 32'd0);
      if (wr) mdl_write(d, a, sz, wd);
      else    check("rnd_rdata", rd, mdl_read(d, a));
    end

    @(negedge hclk); addr_phase(1, 1'b1, 32'h8, 3'd2);
    @(negedge hclk); bus_idle(1); hwdata[1] = 32'hCAFEF00D;
    check("midrst_in_wait", 32'(hready[1]), 32'd0);
    hresetn = 1'b0;
    @(negedge hclk); hresetn = 1'b1;
    check("midrst_hready", 32'(hready[1]), 32'd1);
    check("midrst_hresp",  32'(hresp[1]),  32'd0);
    check("midrst_hrdata", hrdata[1],      32'd0);
    xfer(1, 1'b0, 32'h8, 3'd2, 32'h0, rd, resp, waits);
    check("midrst_write_dropped", rd, mdl_read(1, 32'h8));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
